// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg
//   Shared definitions for the system controller: command opcodes,
//   ALU operand register addresses and the receive-decoder state encoding.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // State literals carry an ST_ prefix so they cannot collide with the
  // decoder's ALU_FUN port once the package is wildcard-imported.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_OPA,
    ST_ALU_OPB,
    ST_ALU_FUN,
    ST_ALU_WAIT
  } rx_state_e;

endpackage

// File: rtl/sys_ctrl_rx_timeout.sv
// sys_ctrl_rx_timeout
//   Loadable down-counter used as the frame watchdog of the receive decoder.
//   Only compiled when SYS_CTRL_RX_TIMEOUT_EN is defined.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   load_i       reload the counter (held high while idle / on progress)
//   expire_o     high for the cycle the counter has run down to zero
`ifdef SYS_CTRL_RX_TIMEOUT_EN
module sys_ctrl_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  // Reload with N-1 so the owner spends exactly N cycles in a silent state.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = LOAD_VAL;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= LOAD_VAL;
    else      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/sys_ctrl_rx_decoder.sv
// sys_ctrl_rx_decoder
//   Receive-side half of the system controller. Decodes UART command frames
//   byte by byte into register-file write/read strobes, ALU operand writes,
//   ALU launches and the ALU clock-gate enable. All outputs are registered.
// Ports:
//   CLK, RST             clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD  received byte and its single-cycle valid strobe
//   OUT_Valid            ALU result valid (ends an ALU frame)
//   RdData_Valid         register-file read data valid (ends a read frame)
//   WrEn, RdEn           one-cycle register-file strobes
//   Address, WrData      register-file address / write data (hold between strobes)
//   ALU_EN, ALU_FUN      one-cycle ALU launch and its function code
//   CLK_EN               ALU clock-gate enable
// Build option:
//   SYS_CTRL_RX_TIMEOUT_EN  abort a stalled frame after TIMEOUT_CYCLES cycles
module sys_ctrl_rx_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  OUT_Valid,
  input  logic                  RdData_Valid,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_EN
);

  rx_state_e             state_q,    state_d;
  logic                  wr_en_q,    wr_en_d;
  logic                  rd_en_q,    rd_en_d;
  logic                  alu_en_q,   alu_en_d;
  logic                  clk_en_q,   clk_en_d;
  logic [ADDR_WIDTH-1:0] address_q,  address_d;
  logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
  logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q,  alu_fun_d;
  logic                  timeout_expired;

  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    clk_en_d   = clk_en_q;
    address_d  = address_q;
    addr_lat_d = addr_lat_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if      (RX_P_DATA == DATA_WIDTH'(CMD_WR))      state_d = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_ALU_OPA;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_ALU_FUN;
        end
      end
      // The write address is parked in a private register so the visible
      // Address keeps its previous value until the WrEn strobe.
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d    = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_lat_q;
          wr_data_d = RX_P_DATA;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_Valid) state_d = ST_IDLE;
      end
      ST_ALU_OPA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(OPA_ADDR);
          wr_data_d = RX_P_DATA;
          state_d   = ST_ALU_OPB;
        end
      end
      ST_ALU_OPB: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_WIDTH'(OPB_ADDR);
          wr_data_d = RX_P_DATA;
          state_d   = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          clk_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (OUT_Valid) begin
          clk_en_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled frame is abandoned without issuing its strobe; operand
    // writes that already went out stay in the register file.
    if (timeout_expired && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;
      alu_en_d = 1'b0;
      clk_en_d = 1'b0;
    end
  end

`ifdef SYS_CTRL_RX_TIMEOUT_EN
  logic timeout_load;

  // Reloaded while idle and on every state change; accepted bytes always
  // advance the state, so that covers byte activity as well.
  assign timeout_load = (state_q == ST_IDLE) || (state_d != state_q);

  sys_ctrl_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .load_i  (timeout_load),
    .expire_o(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      address_q  <= '0;
      addr_lat_q <= '0;
      wr_data_q  <= '0;
      alu_fun_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      clk_en_q   <= clk_en_d;
      address_q  <= address_d;
      addr_lat_q <= addr_lat_d;
      wr_data_q  <= wr_data_d;
      alu_fun_q  <= alu_fun_d;
    end
  end

  assign WrEn    = wr_en_q;
  assign RdEn    = rd_en_q;
  assign ALU_EN  = alu_en_q;
  assign CLK_EN  = clk_en_q;
  assign Address = address_q;
  assign WrData  = wr_data_q;
  assign ALU_FUN = alu_fun_q;

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// tb_sys_ctrl_rx_decoder
//   Directed self-checking bench for sys_ctrl_rx_decoder. Inputs are driven
//   and outputs sampled on the falling clock edge.
// Build option:
//   SYS_CTRL_RX_TIMEOUT_EN  selects the timeout expectations (TIMEOUT_CYCLES=16)
module tb_sys_ctrl_rx_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       OUT_Valid;
  logic       RdData_Valid;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_EN;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  sys_ctrl_rx_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .OUT_Valid   (OUT_Valid),
    .RdData_Valid(RdData_Valid),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .Address     (Address),
    .WrData      (WrData),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .CLK_EN      (CLK_EN)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobes {WrEn,RdEn,ALU_EN,CLK_EN} packed for compact checks.
  function automatic logic [3:0] strobes();
    return {WrEn, RdEn, ALU_EN, CLK_EN};
  endfunction

  // One byte, one idle cycle; on return the byte's strobe cycle is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic pulse_rd_valid();
    @(negedge CLK);
    RdData_Valid = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0;
  endtask

  initial begin
    logic seen_wr;
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
    OUT_Valid = 1'b0; RdData_Valid = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("reset_strobes", 32'(strobes()), 32'h0);
    check_eq("reset_addr",    32'(Address),   32'h0);
    check_eq("reset_wrdata",  32'(WrData),    32'h0);
    check_eq("reset_alufun",  32'(ALU_FUN),   32'h0);
    RST = 1'b1;

    // Write frame AA 05 3C
    send_byte(8'hAA);
    check_eq("wr_cmd_quiet", 32'(strobes()), 32'h0);
    send_byte(8'h05);
    check_eq("wr_addr_quiet", 32'(strobes()), 32'h0);
    check_eq("wr_addr_hold",  32'(Address),   32'h0);
    send_byte(8'h3C);
    check_eq("wr_strobe", 32'(strobes()), 32'b1000);
    check_eq("wr_addr",   32'(Address),   32'h5);
    check_eq("wr_data",   32'(WrData),    32'h3C);
    @(negedge CLK);
    check_eq("wr_one_cycle", 32'(strobes()), 32'h0);
    check_eq("wr_addr_held", 32'(Address),   32'h5);

    // Read frame BB 07, bytes dropped while waiting
    send_byte(8'hBB);
    send_byte(8'h07);
    check_eq("rd_strobe", 32'(strobes()), 32'b0100);
    check_eq("rd_addr",   32'(Address),   32'h7);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11);
    check_eq("rd_wait_drop", 32'(strobes()), 32'h0);
    check_eq("rd_wait_addr", 32'(Address),   32'h7);
    // Completion coincident with a command byte: the byte is dropped.
    @(negedge CLK);
    RdData_Valid = 1'b1; RX_P_DATA = 8'hBB; RX_D_VLD = 1'b1;
    @(negedge CLK);
    RdData_Valid = 1'b0; RX_D_VLD = 1'b0;
    send_byte(8'h07);
    check_eq("rd_coincide_drop", 32'(strobes()), 32'h0);

    // Address truncation on a read
    send_byte(8'hBB);
    send_byte(8'h3A);
    check_eq("rd_trunc_strobe", 32'(strobes()), 32'b0100);
    check_eq("rd_trunc_addr",   32'(Address),   32'hA);
    pulse_rd_valid();

    // ALU with operands CC 12 34 02
    send_byte(8'hCC);
    check_eq("alu_cmd_quiet", 32'(strobes()), 32'h0);
    send_byte(8'h12);
    check_eq("opa_strobe", 32'(strobes()), 32'b1000);
    check_eq("opa_addr",   32'(Address),   32'h0);
    check_eq("opa_data",   32'(WrData),    32'h12);
    send_byte(8'h34);
    check_eq("opb_strobe", 32'(strobes()), 32'b1000);
    check_eq("opb_addr",   32'(Address),   32'h1);
    check_eq("opb_data",   32'(WrData),    32'h34);
    send_byte(8'h02);
    check_eq("alu_launch", 32'(strobes()), 32'b0011);
    check_eq("alu_fun",    32'(ALU_FUN),   32'h2);
    @(negedge CLK);
    check_eq("alu_wait_1", 32'(strobes()), 32'b0001);
    @(negedge CLK);
    OUT_Valid = 1'b1;
    check_eq("alu_wait_valid", 32'(strobes()), 32'b0001);
    @(negedge CLK);
    OUT_Valid = 1'b0;
    check_eq("alu_clken_drop", 32'(strobes()), 32'h0);

    // Garbage byte then ALU without operands DD 08
    send_byte(8'h55);
    check_eq("garbage_quiet", 32'(strobes()), 32'h0);
    send_byte(8'hDD);
    check_eq("nop_cmd_quiet", 32'(strobes()), 32'h0);
    send_byte(8'h08);
    check_eq("nop_launch", 32'(strobes()), 32'b0011);
    check_eq("nop_fun",    32'(ALU_FUN),   32'h8);
    @(negedge CLK);
    OUT_Valid = 1'b1;
    @(negedge CLK);
    OUT_Valid = 1'b0;
    check_eq("nop_done", 32'(strobes()), 32'h0);

    // Back-to-back write AA 0E 5A on consecutive cycles
    @(negedge CLK);
    RX_D_VLD = 1'b1; RX_P_DATA = 8'hAA;
    @(negedge CLK);
    RX_P_DATA = 8'h0E;
    @(negedge CLK);
    RX_P_DATA = 8'h5A;
    check_eq("b2b_quiet", 32'(strobes()), 32'h0);
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    check_eq("b2b_strobe", 32'(strobes()), 32'b1000);
    check_eq("b2b_addr",   32'(Address),   32'hE);
    check_eq("b2b_data",   32'(WrData),    32'h5A);

    // Reset mid-frame, then a read decodes normally
    send_byte(8'hAA);
    send_byte(8'h03);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("abort_strobes", 32'(strobes()), 32'h0);
    check_eq("abort_addr",    32'(Address),   32'h0);
    check_eq("abort_wrdata",  32'(WrData),    32'h0);
    check_eq("abort_alufun",  32'(ALU_FUN),   32'h0);
    RST = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    check_eq("post_abort_rd",   32'(strobes()), 32'b0100);
    check_eq("post_abort_addr", 32'(Address),   32'h3);
    pulse_rd_valid();

    // Stalled write: AA 04 then silence
    send_byte(8'hAA);
    send_byte(8'h04);
    seen_wr = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (WrEn) seen_wr = 1'b1;
    end
    check_eq("stall_no_wren", 32'(seen_wr), 32'h0);
    send_byte(8'h77);
`ifdef SYS_CTRL_RX_TIMEOUT_EN
    check_eq("timeout_dropped", 32'(strobes()), 32'h0);
    send_byte(8'hBB);
    send_byte(8'h02);
    check_eq("timeout_idle_rd", 32'(strobes()), 32'b0100);
    check_eq("timeout_idle_addr", 32'(Address), 32'h2);
    pulse_rd_valid();
`else
    check_eq("stall_still_wr",   32'(strobes()), 32'b1000);
    check_eq("stall_addr",       32'(Address),   32'h4);
    check_eq("stall_data",       32'(WrData),    32'h77);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
